// File: rtl/sys_bridge_n.sv
// CPU-to-peripheral bridge: 16-byte window decode, one-hot write strobes, registered reads, interrupt controller.
// Optional BRIDGE_IRQ_LATCH_EN: edge-latched IRQ_PEND with write-1-to-clear; otherwise level interrupts from irq_q.
module sys_bridge_n #(
    parameter int          DEV_NUM = 3,
    parameter logic [31:0] BASE    = 32'h0000_7F00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            PrAddr,
    input  logic [31:0]            PrWD,
    input  logic [3:0]             PrBE,
    input  logic                   PrWE,
    input  logic                   PrRE,
    output logic [31:0]            PrRD,
    output logic                   PrRdValid,
    output logic                   PrErr,
    output logic [1:0]             DEV_Off,
    output logic [31:0]            DEV_WD,
    output logic [3:0]             DEV_BE,
    output logic [DEV_NUM-1:0]     DEV_WE,
    input  logic [32*DEV_NUM-1:0]  DEV_RD,
    input  logic [DEV_NUM-1:0]     DEV_IRQ,
    output logic [5:0]             HWInt
);

    logic [27:0]        idx;
    logic               hit;
    logic               reg_sel;
    logic [DEV_NUM-1:0] dev_sel;
    logic               rd_req;
    logic               err;
    logic               reg_wr;
    logic [31:0]        dev_rdata;
    logic [31:0]        reg_rdata;
    logic [31:0]        rd_data;
    logic [DEV_NUM-1:0] mask_reg;
    logic [DEV_NUM-1:0] irq_q;
    logic [DEV_NUM-1:0] pend_view;
    logic [DEV_NUM-1:0] hw_src;

    assign idx     = 28'((PrAddr - BASE) >> 4);
    assign hit     = (PrAddr >= BASE) && (idx <= 28'(DEV_NUM));
    assign reg_sel = hit && (idx == 28'(DEV_NUM));

    assign DEV_Off = PrAddr[3:2];
    assign DEV_WD  = PrWD;
    assign DEV_BE  = PrBE;

    genvar gi;
    generate
        for (gi = 0; gi < DEV_NUM; gi++) begin : g_dev
            assign dev_sel[gi] = hit && (idx == 28'(gi));
            // A simultaneous read+write still performs the write.
            assign DEV_WE[gi]  = ~reset & PrWE & dev_sel[gi];
        end
    endgenerate

    // A both-high request is a write; it never produces a read response.
    assign rd_req = PrRE & ~PrWE;
    assign err    = ((PrWE | PrRE) & ~hit) | (PrWE & PrRE);
    assign reg_wr = PrWE & reg_sel & (PrBE == 4'b1111);

    always_comb begin
        dev_rdata = '0;
        for (int i = 0; i < DEV_NUM; i++) begin
            if (dev_sel[i]) dev_rdata = DEV_RD[i*32 +: 32];
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (PrAddr[3:2])
            2'd0:    reg_rdata[DEV_NUM-1:0] = mask_reg;
            2'd1:    reg_rdata[DEV_NUM-1:0] = pend_view;
            2'd2:    reg_rdata[DEV_NUM-1:0] = irq_q;
            default: reg_rdata = 32'(DEV_NUM);
        endcase
    end

    // Unmapped reads fall through to zero because no dev_sel bit is set.
    assign rd_data = reg_sel ? reg_rdata : dev_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PrRD      <= '0;
            PrRdValid <= 1'b0;
            PrErr     <= 1'b0;
            mask_reg  <= '0;
            irq_q     <= '0;
        end else begin
            irq_q     <= DEV_IRQ;
            PrRdValid <= rd_req;
            PrErr     <= err;
            if (rd_req) PrRD <= rd_data;
            if (reg_wr && PrAddr[3:2] == 2'd0) mask_reg <= PrWD[DEV_NUM-1:0];
        end
    end

`ifdef BRIDGE_IRQ_LATCH_EN
    logic [DEV_NUM-1:0] irq_d;
    logic [DEV_NUM-1:0] pend_reg;
    logic [DEV_NUM-1:0] clr;

    assign clr = (reg_wr && PrAddr[3:2] == 2'd1) ? PrWD[DEV_NUM-1:0] : '0;

    // Edge taken one stage after irq_q so pending rises two cycles after DEV_IRQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_d    <= '0;
            pend_reg <= '0;
        end else begin
            irq_d    <= irq_q;
            pend_reg <= (pend_reg & ~clr) | (irq_q & ~irq_d);
        end
    end

    assign pend_view = pend_reg;
    assign hw_src    = pend_reg & mask_reg;
`else
    assign pend_view = irq_q;
    assign hw_src    = irq_q & mask_reg;
`endif

    generate
        for (gi = 0; gi < 6; gi++) begin : g_hw
            if (gi < DEV_NUM) begin : g_on
                assign HWInt[gi] = hw_src[gi];
            end else begin : g_off
                assign HWInt[gi] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed self-checking bench for sys_bridge_n (DEV_NUM=3); expectations follow BRIDGE_IRQ_LATCH_EN if defined.
module tb_sys_bridge_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PrAddr, PrWD;
    logic [3:0]  PrBE;
    logic        PrWE, PrRE;
    logic [31:0] PrRD;
    logic        PrRdValid, PrErr;
    logic [1:0]  DEV_Off;
    logic [31:0] DEV_WD;
    logic [3:0]  DEV_BE;
    logic [2:0]  DEV_WE;
    logic [95:0] DEV_RD;
    logic [2:0]  DEV_IRQ;
    logic [5:0]  HWInt;

    int n_tests = 0;
    int n_fail  = 0;

    sys_bridge_n #(.DEV_NUM(3), .BASE(32'h0000_7F00)) dut (
        .clk(clk), .reset(reset), .PrAddr(PrAddr), .PrWD(PrWD), .PrBE(PrBE),
        .PrWE(PrWE), .PrRE(PrRE), .PrRD(PrRD), .PrRdValid(PrRdValid), .PrErr(PrErr),
        .DEV_Off(DEV_Off), .DEV_WD(DEV_WD), .DEV_BE(DEV_BE), .DEV_WE(DEV_WE),
        .DEV_RD(DEV_RD), .DEV_IRQ(DEV_IRQ), .HWInt(HWInt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_set(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        PrAddr = a; PrWD = d; PrBE = be; PrWE = 1'b1; PrRE = 1'b0;
        #1;
    endtask

    task automatic wr_end();
        cyc();
        PrWE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_set(a, d, be);
        wr_end();
    endtask

    // Issue one read, then check data, valid and no error on the response cycle.
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        PrAddr = a; PrRE = 1'b1; PrWE = 1'b0;
        cyc();
        PrRE = 1'b0;
        chk({tag, "_data"}, PrRD, exp);
        chk({tag, "_valid"}, {31'd0, PrRdValid}, 32'd1);
        chk({tag, "_err"}, {31'd0, PrErr}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; PrAddr = 32'h7F00; PrWD = 0; PrBE = 4'hF; PrWE = 1'b1; PrRE = 1'b0;
        DEV_RD = {32'h12345678, 32'hB1B10001, 32'hA0A00000};
        DEV_IRQ = 3'b000;
        cyc();
        chk("rst_we_forced", {29'd0, DEV_WE}, 32'd0);
        chk("rst_valid", {31'd0, PrRdValid}, 32'd0);
        chk("rst_err", {31'd0, PrErr}, 32'd0);
        chk("rst_rd", PrRD, 32'd0);
        chk("rst_hwint", {26'd0, HWInt}, 32'd0);
        PrWE = 1'b0;
        reset = 1'b0;
        cyc();

        // Device write strobe and pass-through fields.
        wr_set(32'h7F14, 32'hDEAD0001, 4'hF);
        chk("wr_dev_we", {29'd0, DEV_WE}, 32'h2);
        chk("wr_dev_off", {30'd0, DEV_Off}, 32'd1);
        chk("wr_dev_wd", DEV_WD, 32'hDEAD0001);
        chk("wr_dev_be", {28'd0, DEV_BE}, 32'hF);
        wr_end();
        chk("wr_dev_noerr", {31'd0, PrErr}, 32'd0);
        chk("wr_dev_novalid", {31'd0, PrRdValid}, 32'd0);

        rd_chk("rd_dev2", 32'h7F24, 32'h12345678);
        cyc();
        chk("rd_valid_drop", {31'd0, PrRdValid}, 32'd0);
        chk("rd_hold", PrRD, 32'h12345678);

        // Back-to-back reads.
        PrAddr = 32'h7F04; PrRE = 1'b1;
        cyc();
        chk("b2b_0_data", PrRD, 32'hA0A00000);
        chk("b2b_0_valid", {31'd0, PrRdValid}, 32'd1);
        PrAddr = 32'h7F18;
        cyc();
        PrRE = 1'b0;
        chk("b2b_1_data", PrRD, 32'hB1B10001);
        chk("b2b_1_valid", {31'd0, PrRdValid}, 32'd1);

        // Bridge register block.
        wr(32'h7F30, 32'h7, 4'hF);
        rd_chk("mask_rb", 32'h7F30, 32'h7);
        wr(32'h7F30, 32'h0, 4'b0001);
        rd_chk("mask_partial_be", 32'h7F30, 32'h7);
        wr(32'h7F3C, 32'hFFFF_FFFF, 4'hF);
        rd_chk("devnum", 32'h7F3C, 32'h3);

        // Errors.
        rd_chk("pre_err_rd", 32'h7F24, 32'h12345678);
        PrAddr = 32'h7F40; PrRE = 1'b1;
        cyc();
        PrRE = 1'b0;
        chk("unmap_hi_err", {31'd0, PrErr}, 32'd1);
        chk("unmap_hi_rd", PrRD, 32'd0);
        chk("unmap_hi_valid", {31'd0, PrRdValid}, 32'd1);
        rd_chk("pre_err_rd2", 32'h7F14, 32'hB1B10001);
        PrAddr = 32'h1000; PrRE = 1'b1;
        cyc();
        PrRE = 1'b0;
        chk("unmap_lo_err", {31'd0, PrErr}, 32'd1);
        chk("unmap_lo_rd", PrRD, 32'd0);
        chk("unmap_lo_valid", {31'd0, PrRdValid}, 32'd1);
        wr_set(32'h7F40, 32'h1, 4'hF);
        chk("unmap_wr_we", {29'd0, DEV_WE}, 32'd0);
        wr_end();
        chk("unmap_wr_err", {31'd0, PrErr}, 32'd1);
        chk("unmap_wr_valid", {31'd0, PrRdValid}, 32'd0);
        PrAddr = 32'h7F00; PrWD = 32'h55; PrBE = 4'hF; PrWE = 1'b1; PrRE = 1'b1;
        #1;
        chk("both_we", {29'd0, DEV_WE}, 32'h1);
        cyc();
        PrWE = 1'b0; PrRE = 1'b0;
        chk("both_err", {31'd0, PrErr}, 32'd1);
        chk("both_valid", {31'd0, PrRdValid}, 32'd0);
        cyc();
        chk("err_pulse_end", {31'd0, PrErr}, 32'd0);

        // Interrupts with mask 5.
        wr(32'h7F30, 32'h5, 4'hF);
        DEV_IRQ = 3'b001;
        #1;
        chk("irq0_n", {26'd0, HWInt}, 32'd0);
        cyc();
`ifdef BRIDGE_IRQ_LATCH_EN
        chk("irq0_n1", {26'd0, HWInt}, 32'd0);
`else
        chk("irq0_n1", {26'd0, HWInt}, 32'd1);
`endif
        cyc();
        chk("irq0_n2", {26'd0, HWInt}, 32'd1);

        wr(32'h7F34, 32'h1, 4'hF);
        cyc();
        cyc();
`ifdef BRIDGE_IRQ_LATCH_EN
        chk("w1c_no_reset", {26'd0, HWInt}, 32'd0);
`else
        chk("w1c_ignored", {26'd0, HWInt}, 32'd1);
`endif

        DEV_IRQ = 3'b011;
        cyc();
        cyc();
`ifdef BRIDGE_IRQ_LATCH_EN
        rd_chk("pend_irq1", 32'h7F34, 32'h2);
        chk("hw_irq1_masked", {26'd0, HWInt}, 32'd0);
`else
        rd_chk("pend_irq1", 32'h7F34, 32'h3);
        chk("hw_irq1_masked", {26'd0, HWInt}, 32'd1);
`endif

        // Edge on bit 2 coinciding with its write-1-to-clear.
        DEV_IRQ = 3'b111;
        cyc();
        wr(32'h7F34, 32'h4, 4'hF);
`ifdef BRIDGE_IRQ_LATCH_EN
        chk("set_wins_hw", {26'd0, HWInt}, 32'h4);
        rd_chk("set_wins_pend", 32'h7F34, 32'h6);
`else
        chk("set_wins_hw", {26'd0, HWInt}, 32'h5);
        rd_chk("set_wins_pend", 32'h7F34, 32'h7);
`endif
        rd_chk("raw", 32'h7F38, 32'h7);

        // Mask write takes effect the following cycle.
        wr_set(32'h7F30, 32'h0, 4'hF);
`ifdef BRIDGE_IRQ_LATCH_EN
        chk("mask_wr_same", {26'd0, HWInt}, 32'h4);
`else
        chk("mask_wr_same", {26'd0, HWInt}, 32'h5);
`endif
        wr_end();
        chk("mask_wr_next", {26'd0, HWInt}, 32'd0);
        wr(32'h7F30, 32'h7, 4'hF);
`ifdef BRIDGE_IRQ_LATCH_EN
        chk("mask_all", {26'd0, HWInt}, 32'h6);
`else
        chk("mask_all", {26'd0, HWInt}, 32'h7);
`endif

        // Asynchronous reset during a read response.
        PrAddr = 32'h7F24; PrRE = 1'b1;
        cyc();
        PrRE = 1'b0;
        chk("pre_rst_valid", {31'd0, PrRdValid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, PrRdValid}, 32'd0);
        chk("mid_rst_rd", PrRD, 32'd0);
        chk("mid_rst_hwint", {26'd0, HWInt}, 32'd0);
        #2;
        reset = 1'b0;
        cyc();
        rd_chk("post_rst_mask", 32'h7F30, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
